// File: rtl/byte_lane_serializer_if.sv
// byte_lane_serializer_if: lane-bank side (FWFT heads, valids, pops) and registered output byte stream.
interface byte_lane_serializer_if #(
    parameter int BYTES = 32,
    parameter int BYTEWIDTH = 8
);
    localparam int LANEW = $clog2(BYTES);
    logic [BYTES*BYTEWIDTH-1:0] lane_data;
    logic [BYTES-1:0] lane_valid;
    logic [BYTES-1:0] lane_read;
    logic [BYTEWIDTH-1:0] out_data;
    logic [LANEW-1:0] out_lane;
    logic out_last;
    logic out_valid;
    logic out_ready;
    modport master (
        input lane_data, lane_valid, out_ready,
        output lane_read, out_data, out_lane, out_last, out_valid
    );
    modport slave (
        output lane_data, lane_valid, out_ready,
        input lane_read, out_data, out_lane, out_last, out_valid
    );
endinterface

// File: rtl/byte_lane_serializer.sv
// byte_lane_serializer: drains FWFT byte lanes strictly in order 0..BYTES-1 onto a registered byte stream.
// SERIALIZER_BYTECOUNT_EN adds a saturating count of accepted bytes on byte_count.
module byte_lane_serializer #(
    parameter int BYTES = 32,
    parameter int BYTEWIDTH = 8
) (
    input logic clk,
    input logic reset,
    byte_lane_serializer_if.master bus,
    input logic flush
`ifdef SERIALIZER_BYTECOUNT_EN
    ,
    output logic [31:0] byte_count
`endif
);
    localparam int LANEW = $clog2(BYTES);
    localparam logic [LANEW-1:0] LAST = LANEW'(BYTES - 1);
    logic [LANEW-1:0] ptr, ptr_nxt;
    logic take, at_last;
    logic [BYTEWIDTH-1:0] head;
    always_comb begin
        at_last = ptr == LAST;
        take = !reset && (!bus.out_valid || bus.out_ready) && bus.lane_valid[ptr];
        head = bus.lane_data[ptr*BYTEWIDTH +: BYTEWIDTH];
        bus.lane_read = take ? BYTES'(1) << ptr : '0;
        // flush wins over the increment, even when it coincides with a take
        ptr_nxt = flush ? '0 : take ? (at_last ? '0 : ptr + 1'b1) : ptr;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ptr <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_lane <= '0;
            bus.out_last <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
            bus.out_valid <= take || (bus.out_valid && !bus.out_ready);
            if (take) begin
                bus.out_data <= head;
                bus.out_lane <= ptr;
                bus.out_last <= at_last;
            end
        end
`ifdef SERIALIZER_BYTECOUNT_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) byte_count <= '0;
        else if (bus.out_valid && bus.out_ready && !(&byte_count)) byte_count <= byte_count + 1'b1;
`endif
endmodule

// File: doc/byte_lane_serializer.md
Name: byte_lane_serializer

Overview:
- Downstream consumer of the per-byte-lane FIFO bank (first-word-fallthrough lanes).
- Drains lanes strictly in lane order 0..BYTES-1 and wraps, emitting one byte per cycle on a registered valid/ready stream.
- Stalls on an empty lane.
- A flush pulse abandons the rest of a partially written word, so byte-enabled writes of fewer than BYTES lanes do not block the stream.

Parameters:
- BYTES, 32, number of byte lanes; must be ≥ 2.
- BYTEWIDTH, 8, bits per lane.
- LANEW, $clog2(BYTES), width of the lane index (derived; not overridden).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- lane_data  input  BYTES*BYTEWIDTH  fallthrough head data; lane i occupies bits [BYTEWIDTH*(i+1)-1 : BYTEWIDTH*i]
- lane_valid  input  BYTES  lane i FIFO non-empty
- lane_read  output  BYTES  one-hot pop strobe to lane i FIFO
- flush  input  1  single-cycle request: skip the remaining lanes of the current word
- out_data  output  BYTEWIDTH  serialized byte
- out_lane  output  LANEW  source lane of out_data
- out_last  output  1  out_data came from lane BYTES-1
- out_valid  output  1  output register holds a byte
- out_ready  input  1  downstream accepts
- byte_count  output  32  present only with SERIALIZER_BYTECOUNT_EN

Behaviour:
- State: lane pointer ptr (LANEW bits) plus a one-entry output register (out_data, out_lane, out_last, out_valid). No other FSM states.
- Reset (asynchronous, active-high):
  - ptr=0; out_valid=0; out_data=0; out_lane=0; out_last=0.
  - lane_read=0 combinationally while reset is high.
- load_en = !out_valid | out_ready.
- take = load_en & lane_valid[ptr].
- lane_read[ptr] = take, combinational, same cycle. All other lane_read bits are 0. lane_read is never asserted when lane_valid[ptr]=0.
- On take, at the next edge:
  - out_data <= lane_data[ptr]; out_lane <= ptr; out_last <= (ptr==BYTES-1); out_valid <= 1.
  - ptr <= (ptr==BYTES-1) ? 0 : ptr+1.
- If out_valid & out_ready & !take: out_valid <= 0; the data fields hold their values.
- Throughput and latency:
  - Throughput is 1 byte/cycle when lanes are valid and out_ready=1.
  - Latency is 1 cycle from lane head available to out_valid.
- Empty lane at ptr: no pop, ptr holds, stall. Later lanes are not scanned.
- Output full and out_ready=0: no pop, ptr holds. out_* stable while out_valid & !out_ready.
- Flush:
  - flush & !take: ptr <= 0. Skipped lanes are not popped.
  - flush & take: the byte at ptr is captured and popped, then ptr <= 0. Flush takes priority over the normal increment.
  - flush with ptr==0 and no take: no effect.
  - Flush never drops or alters a byte already in the output register.
- Wrap: ptr BYTES-1 → 0 both on a normal take and on flush.
- Reset mid-transfer: a held byte is discarded and out_valid drops asynchronously. Lane FIFOs share the reset and are cleared by their own logic.

Optional Feature:
- Macro: SERIALIZER_BYTECOUNT_EN.
- Defined:
  - Adds output byte_count[31:0], reset to 0.
  - Increments on every out_valid & out_ready cycle.
  - Saturates at 32'hFFFF_FFFF.
  - Flush does not clear it.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- BYTES=4, lanes 0..3 preloaded 8'hA0..8'hA3, out_ready=1 → lane_read one-hot 0001, 0010, 0100, 1000 on consecutive cycles; out_data A0, A1, A2, A3 one cycle later; out_last only on A3; ptr back to 0.
- Lane 2 empty, lanes 0,1,3 valid → A0, A1 emitted, then stall with ptr=2 and no pop of lane 3; push lane 2=8'h5C → 5C emitted next cycle, then lane 3's byte.
- Stream running, out_ready=0 for 3 cycles → out_data/out_lane stable, lane_read=0 throughout; release → no byte lost or duplicated.
- Lanes 0,1 written (8'h11, 8'h22), lanes 2,3 empty; flush pulse one cycle after 22 is taken → ptr=0, lanes 2,3 never read; next word 33,44,55,66 emitted in order with out_lane 0..3.
- flush coincident with a take at ptr=3 → that byte emitted with out_last=1, ptr=0, exactly one pop.
- Assert reset while out_valid=1 and out_ready=0 → out_valid=0 and lane_read=0 immediately; after release ptr=0; with SERIALIZER_BYTECOUNT_EN, 10 accepted bytes → byte_count=10.
